// File: rtl/replica_sweep_scheduler_if.sv
// rtl/replica_sweep_scheduler_if.sv - opt_command type and host/scheduler signal bundle (pause port under REPLICA_SCHED_PAUSE_EN)
package replica_sweep_pkg;
    typedef enum logic {OR1 = 1'b0, TWO = 1'b1} opt_command_t;
endpackage

interface replica_sweep_scheduler_if #(
    parameter int ITER_W = 24,
    parameter int LFSR_W = 16
);
    import replica_sweep_pkg::*;

    logic              start;
    logic              stop;
    logic [ITER_W-1:0] iter_num;
    logic [1:0]        mode;
    logic [LFSR_W-1:0] seed;
`ifdef REPLICA_SCHED_PAUSE_EN
    logic              pause;
`endif
    logic              run;
    opt_command_t      opt_command;
    logic              exchange_parity;
    logic              busy;
    logic              done;
    logic [ITER_W-1:0] iter_cnt;

`ifdef REPLICA_SCHED_PAUSE_EN
    modport master (
        output start, stop, iter_num, mode, seed, pause,
        input  run, opt_command, exchange_parity, busy, done, iter_cnt
    );
    modport slave (
        input  start, stop, iter_num, mode, seed, pause,
        output run, opt_command, exchange_parity, busy, done, iter_cnt
    );
`else
    modport master (
        output start, stop, iter_num, mode, seed,
        input  run, opt_command, exchange_parity, busy, done, iter_cnt
    );
    modport slave (
        input  start, stop, iter_num, mode, seed,
        output run, opt_command, exchange_parity, busy, done, iter_cnt
    );
`endif
endinterface

// File: rtl/replica_sweep_scheduler.sv
// rtl/replica_sweep_scheduler.sv - sweep sequencer issuing spaced run pulses and per-sweep opt/parity; REPLICA_SCHED_PAUSE_EN adds pause
module replica_sweep_scheduler
    import replica_sweep_pkg::*;
#(
    parameter int CYCLE_LEN = 101,
    parameter int ITER_W    = 24,
    parameter int LFSR_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    replica_sweep_scheduler_if.slave bus
);
    localparam int                CNT_W     = (CYCLE_LEN > 2) ? $clog2(CYCLE_LEN) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(CYCLE_LEN - 1);
    // Galois right-shift form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(16'hB400);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ITER_W-1:0] iter_num_q;
    logic [ITER_W-1:0] iter_cnt_q;
    logic [1:0]        mode_q;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_step;
    logic [LFSR_W-1:0] seed_eff;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              stop_pending_q;
    logic              parity_q;
    opt_command_t      opt_q;
    logic              wait_last;
    logic              finish;
    logic              pause_hold;
    logic              run_o;
    logic              done_o;
    logic [1:0]        sel_mode;
    logic              sel_k_odd;
    logic              sel_rnd;

    function automatic opt_command_t pick_opt(input logic [1:0] m, input logic k_odd, input logic rnd);
        case (m)
            2'd0:    return k_odd ? TWO : OR1;
            2'd1:    return OR1;
            2'd2:    return TWO;
            default: return rnd ? TWO : OR1;
        endcase
    endfunction

    assign seed_eff  = (bus.seed == '0) ? LFSR_W'(1) : bus.seed;
    assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    // The counter reaches 0 on the same edge that WAIT is left, so run pulses land CYCLE_LEN apart
    assign wait_last = (wait_cnt_q <= CNT_W'(1));
    assign finish    = (iter_cnt_q == iter_num_q) || stop_pending_q;
`ifdef REPLICA_SCHED_PAUSE_EN
    assign pause_hold = bus.pause;
`else
    assign pause_hold = 1'b0;
`endif

    // The first sweep of a sequence is selected from the values being latched right now
    assign sel_mode  = (state == S_IDLE) ? bus.mode : mode_q;
    assign sel_k_odd = (state == S_IDLE) ? 1'b0 : iter_cnt_q[0];
    assign sel_rnd   = (state == S_IDLE) ? seed_eff[0] : lfsr_q[0];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and pulse outputs
    always_comb begin
        state_nxt = state;
        run_o     = 1'b0;
        done_o    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) state_nxt = (bus.iter_num == '0) ? S_FIN : S_ISSUE;
            end
            S_ISSUE: begin
                run_o     = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (wait_last) begin
                    if (finish)          state_nxt = S_FIN;
                    else if (!pause_hold) state_nxt = S_ISSUE;
                end
            end
            S_FIN: begin
                done_o    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Sequence parameters, sweep counter, spacing counter, LFSR and stop request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iter_num_q     <= '0;
            mode_q         <= 2'd0;
            iter_cnt_q     <= '0;
            lfsr_q         <= LFSR_W'(1);
            wait_cnt_q     <= '0;
            stop_pending_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        iter_num_q     <= bus.iter_num;
                        mode_q         <= bus.mode;
                        lfsr_q         <= seed_eff;
                        iter_cnt_q     <= '0;
                        stop_pending_q <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (iter_cnt_q != iter_num_q) iter_cnt_q <= iter_cnt_q + 1'b1;
                    wait_cnt_q <= CNT_LOAD;
                    lfsr_q     <= lfsr_step;
                    if (bus.stop) stop_pending_q <= 1'b1;
                end
                S_WAIT: begin
                    if (bus.stop) stop_pending_q <= 1'b1;
                    wait_cnt_q <= wait_last ? '0 : wait_cnt_q - 1'b1;
                end
                S_FIN: begin
                    stop_pending_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Command and parity change only on the edge that enters ISSUE, so they hold between runs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opt_q    <= OR1;
            parity_q <= 1'b0;
        end else if (state_nxt == S_ISSUE) begin
            opt_q    <= pick_opt(sel_mode, sel_k_odd, sel_rnd);
            parity_q <= sel_k_odd;
        end
    end

    assign bus.run             = run_o;
    assign bus.done            = done_o;
    assign bus.busy            = (state != S_IDLE);
    assign bus.opt_command     = opt_q;
    assign bus.exchange_parity = parity_q;
    assign bus.iter_cnt        = iter_cnt_q;
endmodule
